univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register. It replaces the fixed 4-bit parallel-load register with a configurable-width register that supports hold, parallel load, shift left/right with serial fill, synchronous clear and, optionally, rotate. A bit-budget counter tracks how many loaded bits have not yet been shifted out. The block sits in the shift-register library, between parallel datapaths and serial links (SPI-style serialisers and deserialisers).

## Interface
Parameters:
- `WIDTH`, default 8: register width. Legal range is `WIDTH >= 2`.
- `RST_VAL`, default 0: value of `data_o` in reset and after clear. Width is `WIDTH`.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `mode_i`  in  3  operation select, sampled each rising edge.
- `data_i`  in  `WIDTH`  parallel load data.
- `sin_l_i`  in  1  serial in; enters at bit 0 on shift left.
- `sin_r_i`  in  1  serial in; enters at bit `WIDTH-1` on shift right.
- `data_o`  out  `WIDTH`  register contents.
- `sout_l_o`  out  1  equals `data_o[WIDTH-1]` (the bit leaving on shift left).
- `sout_r_o`  out  1  equals `data_o[0]` (the bit leaving on shift right).
- `bits_left_o`  out  `$clog2(WIDTH+1)`  count of loaded bits not yet shifted out.
- `empty_o`  out  1  high when `bits_left_o == 0`.

## Operation
Each rising edge performs the action selected by `mode_i`:
- **3'b000, hold:** all state unchanged.
- **3'b001, load:** `data_o <= data_i`; `bits_left_o <= WIDTH`.
- **3'b010, shift left:** `data_o <= {data_o[WIDTH-2:0], sin_l_i}`; `bits_left_o` decrements, saturating at 0.
- **3'b011, shift right:** `data_o <= {sin_r_i, data_o[WIDTH-1:1]}`; `bits_left_o` decrements, saturating at 0.
- **3'b100, rotate left:** `data_o <= {data_o[WIDTH-2:0], data_o[WIDTH-1]}`; `bits_left_o` unchanged.
- **3'b101, rotate right:** `data_o <= {data_o[0], data_o[WIDTH-1:1]}`; `bits_left_o` unchanged.
- **3'b110 and 3'b111, clear:** `data_o <= RST_VAL`; `bits_left_o <= 0`.

Rules and boundary conditions:
- Shifting when `bits_left_o == 0` still shifts the data. The counter stays at 0 and does not wrap.
- A load during a partially shifted word discards the remaining bits and sets the counter to `WIDTH`.
- `sout_l_o`, `sout_r_o` and `empty_o` are combinational decodes of registered state only. They do not depend on any input.
- Exactly one action occurs per cycle. Because the mode is encoded, simultaneous operations cannot occur.

## Timing
- Reset values: `data_o = RST_VAL`, `bits_left_o = 0`, `empty_o = 1`. Consequently `sout_l_o = RST_VAL[WIDTH-1]` and `sout_r_o = RST_VAL[0]`.
- Reset assertion takes effect immediately, with no clock required. This applies even in the middle of a shift sequence.
- After reset deassertion, the first rising edge executes `mode_i` normally.
- Latency is 1 cycle: inputs sampled at edge N appear on `data_o` and `bits_left_o` after edge N.
- The serial outputs present the bit that the next shift will consume. That bit remains valid until the edge that shifts it out.
- A full word shift-out takes exactly `WIDTH` shift cycles after a load. `empty_o` rises after the `WIDTH`-th shift edge.

## Configuration
- Macro: `UNIV_SHIFT_REG_ROTATE_EN`.
- **Defined:** modes 3'b100 and 3'b101 rotate as described in Operation.
- **Undefined:** modes 3'b100 and 3'b101 behave exactly as hold (3'b000), and no rotate muxing is synthesised. All other modes are identical in both builds.

## Test plan
All scenarios use `WIDTH=8` and `RST_VAL=0`.
- **Async reset mid-shift:** load 0xA5, shift left twice, then pull `rst_n_i` low between edges. Expect `data_o=0x00`, `bits_left_o=0` and `empty_o=1` before the next edge.
- **Load then shift left:** load 0xA5, then shift left with `sin_l_i=1`. Expect `data_o=0x4B`, `bits_left_o=7`, and `sout_l_o=1` before the shift edge.
- **Shift-out boundary:** load 0xA5, then 8 shift-right cycles with `sin_r_i=0`. Expect `sout_r_o` sequence 1,0,1,0,0,1,0,1 and `data_o=0x00`; `empty_o` rises after the 8th edge. A 9th shift with `sin_r_i=1` gives `data_o=0x80` with `bits_left_o` still 0.
- **Reload mid-word:** load 0xFF, shift left 3 times, then load 0x3C. Expect `data_o=0x3C` and `bits_left_o=8`.
- **Rotate:** load 0x81, then rotate left. With the macro defined, expect `data_o=0x03` and `bits_left_o=8`. With it undefined, expect `data_o=0x81` (held).
- **Clear:** load 0x5A, then apply mode 3'b111. Expect `data_o=0x00`, `bits_left_o=0` and `empty_o=1`. Hold for 3 cycles and expect no change.

Source files
------------

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Brief    : Parametrised universal shift register with bit-budget counter.
//            Rotate modes enabled by defining UNIV_SHIFT_REG_ROTATE_EN.
// Revision : 1.0
// ============================================================================
module univ_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [2:0]                 mode_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       sin_l_i,
   input  logic                       sin_r_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       sout_l_o,
   output logic                       sout_r_o,
   output logic [$clog2(WIDTH+1)-1:0] bits_left_o,
   output logic                       empty_o
);

   localparam int CW = $clog2(WIDTH+1);

   localparam logic [2:0]    c_MODE_HOLD  = 3'b000;
   localparam logic [2:0]    c_MODE_LOAD  = 3'b001;
   localparam logic [2:0]    c_MODE_SHL   = 3'b010;
   localparam logic [2:0]    c_MODE_SHR   = 3'b011;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
   localparam logic [2:0]    c_MODE_ROTL  = 3'b100;
   localparam logic [2:0]    c_MODE_ROTR  = 3'b101;
`endif
   localparam logic [2:0]    c_MODE_CLR0  = 3'b110;
   localparam logic [2:0]    c_MODE_CLR1  = 3'b111;
   localparam logic [CW-1:0] c_FULL_COUNT = CW'(WIDTH);

   logic [WIDTH-1:0] r_data;
   logic [CW-1:0]    r_bits_left;
   logic [CW-1:0]    w_bits_dec;

   // Budget never wraps: shifting an exhausted word still moves data.
   assign w_bits_dec = (r_bits_left == '0) ? '0 : r_bits_left - CW'(1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_data      <= RST_VAL;
         r_bits_left <= '0;
      end else begin
         case (mode_i)
            c_MODE_HOLD: begin
               r_data      <= r_data;
               r_bits_left <= r_bits_left;
            end
            c_MODE_LOAD: begin
               r_data      <= data_i;
               r_bits_left <= c_FULL_COUNT;
            end
            c_MODE_SHL: begin
               r_data      <= {r_data[WIDTH-2:0], sin_l_i};
               r_bits_left <= w_bits_dec;
            end
            c_MODE_SHR: begin
               r_data      <= {sin_r_i, r_data[WIDTH-1:1]};
               r_bits_left <= w_bits_dec;
            end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
            c_MODE_ROTL: begin
               r_data      <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
               r_bits_left <= r_bits_left;
            end
            c_MODE_ROTR: begin
               r_data      <= {r_data[0], r_data[WIDTH-1:1]};
               r_bits_left <= r_bits_left;
            end
`endif
            c_MODE_CLR0, c_MODE_CLR1: begin
               r_data      <= RST_VAL;
               r_bits_left <= '0;
            end
            default: begin
               r_data      <= r_data;
               r_bits_left <= r_bits_left;
            end
         endcase
      end
   end

   assign data_o      = r_data;
   assign bits_left_o = r_bits_left;
   assign sout_l_o    = r_data[WIDTH-1];
   assign sout_r_o    = r_data[0];
   assign empty_o     = (r_bits_left == '0);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Brief    : Directed + random checks of univ_shift_reg against a word model.
// Revision : 1.0
// ============================================================================
module tb_univ_shift_reg;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH+1);

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic [2:0]       mode_i;
   logic [WIDTH-1:0] data_i;
   logic             sin_l_i;
   logic             sin_r_i;
   logic [WIDTH-1:0] data_o;
   logic             sout_l_o;
   logic             sout_r_o;
   logic [CW-1:0]    bits_left_o;
   logic             empty_o;

   int total = 0;
   int bad   = 0;
   int m_data;
   int m_cnt;
   int mask  = (1 << WIDTH) - 1;

   always #5 clk_i = ~clk_i;

   univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL('0)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .mode_i      (mode_i),
      .data_i      (data_i),
      .sin_l_i     (sin_l_i),
      .sin_r_i     (sin_r_i),
      .data_o      (data_o),
      .sout_l_o    (sout_l_o),
      .sout_r_o    (sout_r_o),
      .bits_left_o (bits_left_o),
      .empty_o     (empty_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".data"},  32'(data_o),      32'(m_data));
      chk({tag, ".bits"},  32'(bits_left_o), 32'(m_cnt));
      chk({tag, ".empty"}, 32'(empty_o),     32'(m_cnt == 0));
      chk({tag, ".soutl"}, 32'(sout_l_o),    32'((m_data >> (WIDTH-1)) & 1));
      chk({tag, ".soutr"}, 32'(sout_r_o),    32'(m_data & 1));
   endtask

   task automatic model_reset();
      m_data = 0;
      m_cnt  = 0;
   endtask

   // One clocked operation: drive, take the edge, advance the model, compare.
   task automatic step(input string tag, input logic [2:0] mode, input logic [WIDTH-1:0] d,
                       input logic sl, input logic sr);
      int od;
      mode_i  = mode;
      data_i  = d;
      sin_l_i = sl;
      sin_r_i = sr;
      @(posedge clk_i);
      od = m_data;
      case (mode)
         3'd1: begin m_data = int'(d); m_cnt = WIDTH; end
         3'd2: begin m_data = ((od << 1) | int'(sl)) & mask; m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0; end
         3'd3: begin m_data = (od >> 1) | (int'(sr) << (WIDTH-1)); m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0; end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
         3'd4: m_data = ((od << 1) | (od >> (WIDTH-1))) & mask;
         3'd5: m_data = (od >> 1) | ((od & 1) << (WIDTH-1));
`endif
         3'd6, 3'd7: begin m_data = 0; m_cnt = 0; end
         default: ;
      endcase
      #1;
      check_model(tag);
   endtask

   initial begin
      logic seq [8];
      seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      rst_n_i = 1'b0;
      mode_i  = 3'd0;
      data_i  = '0;
      sin_l_i = 1'b0;
      sin_r_i = 1'b0;
      model_reset();
      #1;
      check_model("reset");
      chk("reset.empty_const", 32'(empty_o), 32'd1);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Async reset in the middle of a shift sequence
      step("ar.load", 3'd1, 8'hA5, 1'b0, 1'b0);
      step("ar.shl1", 3'd2, 8'h00, 1'b1, 1'b0);
      step("ar.shl2", 3'd2, 8'h00, 1'b0, 1'b0);
      #2;
      rst_n_i = 1'b0;
      #1;
      model_reset();
      check_model("ar.async");
      chk("ar.data_const", 32'(data_o), 32'h00);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Load then shift left
      step("ls.load", 3'd1, 8'hA5, 1'b0, 1'b0);
      chk("ls.soutl_pre", 32'(sout_l_o), 32'd1);
      step("ls.shl", 3'd2, 8'h00, 1'b1, 1'b0);
      chk("ls.data_const", 32'(data_o), 32'h4B);
      chk("ls.bits_const", 32'(bits_left_o), 32'd7);

      // Shift-out boundary
      step("so.load", 3'd1, 8'hA5, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("so.soutr%0d", i), 32'(sout_r_o), 32'(seq[i]));
         chk($sformatf("so.empty_pre%0d", i), 32'(empty_o), 32'd0);
         step($sformatf("so.shr%0d", i), 3'd3, 8'h00, 1'b0, 1'b0);
      end
      chk("so.data_const", 32'(data_o), 32'h00);
      chk("so.empty_const", 32'(empty_o), 32'd1);
      step("so.shr9", 3'd3, 8'h00, 1'b0, 1'b1);
      chk("so.data9_const", 32'(data_o), 32'h80);
      chk("so.bits9_const", 32'(bits_left_o), 32'd0);

      // Reload mid-word
      step("rl.load", 3'd1, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("rl.shl", 3'd2, 8'h00, 1'b0, 1'b0);
      step("rl.reload", 3'd1, 8'h3C, 1'b0, 1'b0);
      chk("rl.data_const", 32'(data_o), 32'h3C);
      chk("rl.bits_const", 32'(bits_left_o), 32'd8);

      // Rotate
      step("ro.load", 3'd1, 8'h81, 1'b0, 1'b0);
      step("ro.rotl", 3'd4, 8'h00, 1'b1, 1'b1);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      chk("ro.data_const", 32'(data_o), 32'h03);
`else
      chk("ro.data_const", 32'(data_o), 32'h81);
`endif
      chk("ro.bits_const", 32'(bits_left_o), 32'd8);
      step("ro.rotr", 3'd5, 8'h00, 1'b0, 1'b0);

      // Clear, then hold
      step("cl.load", 3'd1, 8'h5A, 1'b0, 1'b0);
      step("cl.clr", 3'd7, 8'hFF, 1'b1, 1'b1);
      chk("cl.data_const", 32'(data_o), 32'h00);
      chk("cl.empty_const", 32'(empty_o), 32'd1);
      for (int i = 0; i < 3; i++) step("cl.hold", 3'd0, 8'hFF, 1'b1, 1'b1);
      step("cl.clr6", 3'd6, 8'h00, 1'b0, 1'b0);

      // Random traffic, shifts weighted up, with one async reset midway
      for (int i = 0; i < 400; i++) begin
         logic [2:0] m;
         int r;
         r = $urandom_range(0, 15);
         if (r < 3)       m = 3'd1;
         else if (r < 7)  m = 3'd2;
         else if (r < 11) m = 3'd3;
         else             m = 3'($urandom_range(0, 7));
         step($sformatf("rnd%0d", i), m, 8'($urandom), 1'($urandom), 1'($urandom));
         if (i == 200) begin
            #3;
            rst_n_i = 1'b0;
            #1;
            model_reset();
            check_model("rnd.async");
            @(negedge clk_i);
            rst_n_i = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
